vsync_gen: RTL and testbench

Parametrised vertical timing generator for the VGA pipeline. It counts line strobes from the horizontal generator, not raw clocks, and produces the vertical sync pulse, the vertical display-enable and a scaled framebuffer row index. It also provides frame boundary strobes and a synchronous restart. It sits between the horizontal timing block and the pixel/framebuffer fetch logic.

---
 rtl/vsync_gen.sv | 152 +++++++++++++++
 tb/tb_vsync_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vsync_gen.sv
// Vertical timing generator: counts accepted line strobes and produces vsync,
// vertical display-enable, a scaled framebuffer row index and frame strobes.
module vsync_gen #(
    parameter int   V_PULSE  = 2,
    parameter int   V_BACK   = 29,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SCALE  = 5,
    parameter int   ROW_W    = 7,
    parameter int   LINE_W   = 10,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_line_tick,
    input  logic              i_restart,
    output logic              o_vga_vsync,
    output logic              o_vde,
    output logic [ROW_W-1:0]  o_vrow,
    output logic [LINE_W-1:0] o_vline,
    output logic              o_frame_start,
    output logic              o_frame_end
);

    localparam int TOTAL = V_PULSE + V_BACK + V_ACTIVE + V_FRONT;
    localparam int ROWS  = (V_SCALE > 0) ? V_ACTIVE / V_SCALE : 0;
    localparam int SUB_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    localparam logic [LINE_W-1:0] L_SYNC_END = LINE_W'(V_PULSE - 1);
    localparam logic [LINE_W-1:0] L_BACK_END = LINE_W'(V_PULSE + V_BACK - 1);
    localparam logic [LINE_W-1:0] L_ACT_END  = LINE_W'(V_PULSE + V_BACK + V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] L_LAST     = LINE_W'(TOTAL - 1);
    localparam logic [SUB_W-1:0]  L_SUB_LAST = SUB_W'(V_SCALE - 1);

    if (V_PULSE < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1 || V_SCALE < 1) begin : g_bad_len
        $error("vsync_gen: all phase lengths and V_SCALE must be at least 1");
    end
    if (V_SCALE >= 1 && (V_ACTIVE % V_SCALE) != 0) begin : g_bad_scale
        $error("vsync_gen: V_ACTIVE must be a multiple of V_SCALE");
    end
    if ((64'd1 << LINE_W) < 64'(TOTAL)) begin : g_bad_line_w
        $error("vsync_gen: LINE_W too small for the frame length");
    end
    if ((64'd1 << ROW_W) < 64'(ROWS)) begin : g_bad_row_w
        $error("vsync_gen: ROW_W too small for the number of rows");
    end

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [LINE_W-1:0]   r_vline, w_vline_nxt;
    logic [SUB_W-1:0]    r_sub, w_sub_nxt;
    logic [ROW_W-1:0]    r_vrow, w_vrow_nxt;
    logic                r_vsync, w_vsync_nxt;
    logic                r_vde, w_vde_nxt;
    logic                r_fs, w_fs_nxt;
    logic                r_fe, w_fe_nxt;
    logic                w_accept;
    logic                w_phase_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SYNC;
            r_vline <= '0;
            r_sub   <= '0;
            r_vrow  <= '0;
            r_vsync <= SYNC_POL;
            r_vde   <= 1'b0;
            r_fs    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vline <= w_vline_nxt;
            r_sub   <= w_sub_nxt;
            r_vrow  <= w_vrow_nxt;
            r_vsync <= w_vsync_nxt;
            r_vde   <= w_vde_nxt;
            r_fs    <= w_fs_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    // Phase boundaries are absolute line numbers, so no separate phase counter is needed.
    always_comb begin
        w_accept     = i_line_tick & i_en;
        w_phase_last = 1'b0;
        case (r_state)
            ST_SYNC:   w_phase_last = (r_vline == L_SYNC_END);
            ST_BACK:   w_phase_last = (r_vline == L_BACK_END);
            ST_ACTIVE: w_phase_last = (r_vline == L_ACT_END);
            ST_FRONT:  w_phase_last = (r_vline == L_LAST);
            default:   w_phase_last = 1'b0;
        endcase

        w_state_nxt = r_state;
        w_vline_nxt = r_vline;
        w_sub_nxt   = r_sub;
        w_vrow_nxt  = r_vrow;
        w_fs_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;

        if (i_restart) begin
            w_state_nxt = ST_SYNC;
            w_vline_nxt = '0;
            w_sub_nxt   = '0;
            w_vrow_nxt  = '0;
            w_fs_nxt    = 1'b1;
        end else if (w_accept) begin
            w_vline_nxt = (r_vline == L_LAST) ? '0 : r_vline + 1'b1;
            w_fs_nxt    = (r_vline == L_LAST);
            w_fe_nxt    = (r_vline == L_LAST);
            if (w_phase_last) begin
                case (r_state)
                    ST_SYNC:   w_state_nxt = ST_BACK;
                    ST_BACK:   w_state_nxt = ST_ACTIVE;
                    ST_ACTIVE: w_state_nxt = ST_FRONT;
                    default:   w_state_nxt = ST_SYNC;
                endcase
            end
            if (r_state == ST_ACTIVE) begin
                if (r_sub == L_SUB_LAST) begin
                    w_sub_nxt  = '0;
                    w_vrow_nxt = r_vrow + 1'b1;
                end else begin
                    w_sub_nxt  = r_sub + 1'b1;
                end
            end
            // Leaving ACTIVE would otherwise carry vrow one past its maximum.
            if (w_state_nxt != ST_ACTIVE) begin
                w_sub_nxt  = '0;
                w_vrow_nxt = '0;
            end
        end

        w_vsync_nxt = (w_state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        w_vde_nxt   = (w_state_nxt == ST_ACTIVE);
    end

    assign o_vga_vsync   = r_vsync;
    assign o_vde         = r_vde;
    assign o_vrow        = r_vrow;
    assign o_vline       = r_vline;
    assign o_frame_start = r_fs;
    assign o_frame_end   = r_fe;

endmodule

// File: tb/tb_vsync_gen.sv
// Scoreboard bench for vsync_gen: a default-size and a small instance are driven
// together; a line-number reference model predicts every post-edge output.
module tb_vsync_gen;

    typedef struct {
        int pulse;
        int back;
        int active;
        int front;
        int scale;
        int pol;
    } cfg_t;

    typedef struct {
        int vsync;
        int vde;
        int vrow;
        int vline;
        int fs;
        int fe;
    } obs_t;

    localparam cfg_t CFG_A = '{pulse: 2, back: 29, active: 480, front: 10, scale: 5, pol: 0};
    localparam cfg_t CFG_B = '{pulse: 1, back: 1, active: 4, front: 1, scale: 2, pol: 1};

    logic clk = 1'b0;
    logic rst_n;
    logic a_en, a_tick, a_restart;
    logic b_en, b_tick, b_restart;

    logic       a_vsync, a_vde, a_fs, a_fe;
    logic [6:0] a_vrow;
    logic [9:0] a_vline;
    logic       b_vsync, b_vde, b_fs, b_fe;
    logic [0:0] b_vrow;
    logic [2:0] b_vline;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    obs_t qa[$];
    obs_t qb[$];

    int ma_line = 0, ma_fs = 0, ma_fe = 0;
    int mb_line = 0, mb_fs = 0, mb_fe = 0;

    always #5 clk = ~clk;

    vsync_gen dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_line_tick(a_tick), .i_restart(a_restart),
        .o_vga_vsync(a_vsync), .o_vde(a_vde), .o_vrow(a_vrow), .o_vline(a_vline),
        .o_frame_start(a_fs), .o_frame_end(a_fe)
    );

    vsync_gen #(
        .V_PULSE(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .V_SCALE(2),
        .ROW_W(1), .LINE_W(3), .SYNC_POL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_line_tick(b_tick), .i_restart(b_restart),
        .o_vga_vsync(b_vsync), .o_vde(b_vde), .o_vrow(b_vrow), .o_vline(b_vline),
        .o_frame_start(b_fs), .o_frame_end(b_fe)
    );

    function automatic int total_of(input cfg_t c);
        return c.pulse + c.back + c.active + c.front;
    endfunction

    // Outputs follow directly from the line number and the phase lengths.
    function automatic obs_t expect_of(input cfg_t c, input int line, input int fs, input int fe);
        obs_t o;
        int a0;
        a0      = c.pulse + c.back;
        o.vline = line;
        o.vsync = (line < c.pulse) ? c.pol : 1 - c.pol;
        o.vde   = (line >= a0 && line < a0 + c.active) ? 1 : 0;
        o.vrow  = (o.vde == 1) ? (line - a0) / c.scale : 0;
        o.fs    = fs;
        o.fe    = fe;
        return o;
    endfunction

    function automatic void model_step(input cfg_t c, input int tick, input int en, input int rstn,
                                       input int restart, inout int line, inout int fs, inout int fe);
        if (rstn == 0) begin
            line = 0; fs = 0; fe = 0;
        end else if (restart != 0) begin
            line = 0; fs = 1; fe = 0;
        end else if (tick != 0 && en != 0) begin
            fe   = (line == total_of(c) - 1) ? 1 : 0;
            line = (line + 1) % total_of(c);
            fs   = (line == 0) ? 1 : 0;
        end else begin
            fs = 0; fe = 0;
        end
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '{vsync: int'(a_vsync), vde: int'(a_vde), vrow: int'(a_vrow), vline: int'(a_vline),
              fs: int'(a_fs), fe: int'(a_fe)};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{vsync: int'(b_vsync), vde: int'(b_vde), vrow: int'(b_vrow), vline: int'(b_vline),
              fs: int'(b_fs), fe: int'(b_fe)};
        return o;
    endfunction

    function automatic bit same(input obs_t x, input obs_t y);
        return x.vsync == y.vsync && x.vde == y.vde && x.vrow == y.vrow &&
               x.vline == y.vline && x.fs == y.fs && x.fe == y.fe;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (!same(act, exp)) begin
            n_bad++;
            $display("FAIL %s t=%0t got vs=%0d de=%0d row=%0d line=%0d fs=%0d fe=%0d want vs=%0d de=%0d row=%0d line=%0d fs=%0d fe=%0d",
                     name, $time, act.vsync, act.vde, act.vrow, act.vline, act.fs, act.fe,
                     exp.vsync, exp.vde, exp.vrow, exp.vline, exp.fs, exp.fe);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_queue_empty t=%0t got 0 entries want 1", $time);
            end else begin
                check("a_scoreboard", obs_a(), qa.pop_front());
            end
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_queue_empty t=%0t got 0 entries want 1", $time);
            end else begin
                check("b_scoreboard", obs_b(), qb.pop_front());
            end
        end
    end

    task automatic drive(input logic ta, input logic ea, input logic ra,
                         input logic tb, input logic eb, input logic rb);
        a_tick = ta; a_en = ea; a_restart = ra;
        b_tick = tb; b_en = eb; b_restart = rb;
        model_step(CFG_A, int'(ta), int'(ea), int'(rst_n), int'(ra), ma_line, ma_fs, ma_fe);
        qa.push_back(expect_of(CFG_A, ma_line, ma_fs, ma_fe));
        model_step(CFG_B, int'(tb), int'(eb), int'(rst_n), int'(rb), mb_line, mb_fs, mb_fe);
        qb.push_back(expect_of(CFG_B, mb_line, mb_fs, mb_fe));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic ta, input logic ea, input logic ra);
        drive(ta, ea, ra, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drive_rand();
        drive($urandom_range(2) == 0, $urandom_range(7) != 0, $urandom_range(199) == 0,
              $urandom_range(1) == 0, $urandom_range(7) != 0, $urandom_range(49) == 0);
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("a_async_reset", obs_a(), expect_of(CFG_A, 0, 0, 0));
        check("b_async_reset", obs_b(), expect_of(CFG_B, 0, 0, 0));
        ma_line = 0; ma_fs = 0; ma_fe = 0;
        mb_line = 0; mb_fs = 0; mb_fe = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_tick = 1'b0; a_en = 1'b1; a_restart = 1'b0;
        b_tick = 1'b0; b_en = 1'b1; b_restart = 1'b0;
        #1;
        mon_on = 1'b1;

        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Two full default frames, one tick every 8 clocks.
        for (int t = 0; t < 1042; t++) begin
            drive_a(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 7; k++) drive_a(1'b0, 1'b1, 1'b0);
        end

        for (int g = 0; g < 600 && ma_line != 200; g++) begin
            drive_a(1'b1, 1'b1, 1'b0);
            drive_a(1'b0, 1'b1, 1'b0);
        end
        for (int t = 0; t < 50; t++) begin
            drive_a(1'b1, 1'b0, 1'b0);
            drive_a(1'b0, 1'b0, 1'b0);
        end
        for (int g = 0; g < 600 && ma_line != 300; g++) begin
            drive_a(1'b1, 1'b1, 1'b0);
            drive_a(1'b0, 1'b1, 1'b0);
        end
        drive_a(1'b1, 1'b1, 1'b1);
        drive_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) drive_rand();

        drive_a(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) drive_a(1'b1, 1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL queue_drain got %0d/%0d entries want 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
